// File: rtl/memory_port_arbiter.sv
// Two-port arbiter in front of a single byte-addressable memory with a 1-cycle registered read.
// Port 0 is a word-read-only fetch port; port 1 is a load/store port. Read data is steered back to its issuer.
module memory_port_arbiter #(
    parameter int MEMORY_DEPTH_BYTES = 1024,
    parameter int ROUND_ROBIN        = 1,
    localparam int AddrWidth         = $clog2(MEMORY_DEPTH_BYTES)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,

    input  logic                 p0_req_i,
    input  logic [AddrWidth-1:0] p0_addr_i,
    output logic                 p0_gnt_o,
    output logic                 p0_rvalid_o,
    output logic [31:0]          p0_rdata_o,

    input  logic                 p1_req_i,
    input  logic                 p1_we_i,
    input  logic [1:0]           p1_width_i,
    input  logic                 p1_sign_extend_i,
    input  logic [AddrWidth-1:0] p1_addr_i,
    input  logic [31:0]          p1_wdata_i,
    output logic                 p1_gnt_o,
    output logic                 p1_rvalid_o,
    output logic [31:0]          p1_rdata_o,

    output logic [AddrWidth-1:0] mem_addr_o,
    output logic [1:0]           mem_width_o,
    output logic                 mem_sign_extend_o,
    output logic [31:0]          mem_wdata_o,
    output logic                 mem_we_o,
    input  logic [31:0]          mem_rdata_i
);

    // mem_width_t encoding shared with the memory: 0 = BYTE, 1 = HALFWORD, 2 = WORD.
    localparam logic [1:0] WIDTH_WORD = 2'd2;

    // Handshake: a requester raises req with stable fields and keeps them until it
    // sees its gnt high in the same cycle; the transfer happens on req && gnt.
    logic last_port_q, last_port_d;
    logic rsp_valid_q, rsp_valid_d;
    logic rsp_port_q,  rsp_port_d;
    logic gnt0, gnt1;

    // Contention goes to the port that was not served last; a sole requester always wins.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst_i) begin
            if (p0_req_i && p1_req_i) begin
                if (ROUND_ROBIN != 0 && last_port_q) begin
                    gnt0 = 1'b1;
                end else begin
                    gnt1 = 1'b1;
                end
            end else begin
                gnt0 = p0_req_i;
                gnt1 = p1_req_i;
            end
        end
    end

    always_comb begin
        last_port_d = last_port_q;
        if (gnt1) begin
            last_port_d = 1'b1;
        end else if (gnt0) begin
            last_port_d = 1'b0;
        end
        rsp_valid_d = gnt0 || (gnt1 && !p1_we_i);
        rsp_port_d  = gnt1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_port_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_port_q  <= 1'b0;
        end else begin
            last_port_q <= last_port_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_port_q  <= rsp_port_d;
        end
    end

    // With no grant the memory sees a harmless port 0 read.
    always_comb begin
        if (gnt1) begin
            mem_addr_o        = p1_addr_i;
            mem_width_o       = p1_width_i;
            mem_sign_extend_o = p1_sign_extend_i;
            mem_wdata_o       = p1_wdata_i;
        end else begin
            mem_addr_o        = p0_addr_i;
            mem_width_o       = WIDTH_WORD;
            mem_sign_extend_o = 1'b0;
            mem_wdata_o       = 32'd0;
        end
        mem_we_o = gnt1 && p1_we_i;
    end

    assign p0_gnt_o = gnt0;
    assign p1_gnt_o = gnt1;

    // A response still in flight when reset rises is dropped.
    assign p0_rvalid_o = rsp_valid_q && !rsp_port_q && !rst_i;
    assign p1_rvalid_o = rsp_valid_q &&  rsp_port_q && !rst_i;
    assign p0_rdata_o  = p0_rvalid_o ? mem_rdata_i : 32'd0;
    assign p1_rdata_o  = p1_rvalid_o ? mem_rdata_i : 32'd0;

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Bench for memory_port_arbiter: a byte-array memory, a transaction-level reference
// model of the arbitration rules, directed scenarios and randomized traffic.
module tb_memory_port_arbiter;

    localparam int AW    = 10;
    localparam int DEPTH = 1024;
    localparam logic [1:0] W_BYTE = 2'd0;
    localparam logic [1:0] W_HALF = 2'd1;
    localparam logic [1:0] W_WORD = 2'd2;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          p0_req_i;
    logic [AW-1:0] p0_addr_i;
    logic          p1_req_i, p1_we_i, p1_sign_extend_i;
    logic [1:0]    p1_width_i;
    logic [AW-1:0] p1_addr_i;
    logic [31:0]   p1_wdata_i;
    logic          p0_gnt_o, p0_rvalid_o, p1_gnt_o, p1_rvalid_o;
    logic [31:0]   p0_rdata_o, p1_rdata_o;
    logic [AW-1:0] mem_addr_o;
    logic [1:0]    mem_width_o;
    logic          mem_sign_extend_o, mem_we_o;
    logic [31:0]   mem_wdata_o;
    logic [31:0]   mem_rdata_i;

    // Fixed-priority instance sharing the same request inputs.
    logic          f_p0_gnt, f_p0_rvalid, f_p1_gnt, f_p1_rvalid;
    logic [31:0]   f_p0_rdata, f_p1_rdata, f_mem_wdata;
    logic [AW-1:0] f_mem_addr;
    logic [1:0]    f_mem_width;
    logic          f_mem_se, f_mem_we;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    memory_port_arbiter #(.MEMORY_DEPTH_BYTES(DEPTH), .ROUND_ROBIN(1)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .p0_req_i(p0_req_i), .p0_addr_i(p0_addr_i), .p0_gnt_o(p0_gnt_o),
        .p0_rvalid_o(p0_rvalid_o), .p0_rdata_o(p0_rdata_o),
        .p1_req_i(p1_req_i), .p1_we_i(p1_we_i), .p1_width_i(p1_width_i),
        .p1_sign_extend_i(p1_sign_extend_i), .p1_addr_i(p1_addr_i), .p1_wdata_i(p1_wdata_i),
        .p1_gnt_o(p1_gnt_o), .p1_rvalid_o(p1_rvalid_o), .p1_rdata_o(p1_rdata_o),
        .mem_addr_o(mem_addr_o), .mem_width_o(mem_width_o),
        .mem_sign_extend_o(mem_sign_extend_o), .mem_wdata_o(mem_wdata_o),
        .mem_we_o(mem_we_o), .mem_rdata_i(mem_rdata_i)
    );

    memory_port_arbiter #(.MEMORY_DEPTH_BYTES(DEPTH), .ROUND_ROBIN(0)) dut_fixed (
        .clk_i(clk), .rst_i(rst_i),
        .p0_req_i(p0_req_i), .p0_addr_i(p0_addr_i), .p0_gnt_o(f_p0_gnt),
        .p0_rvalid_o(f_p0_rvalid), .p0_rdata_o(f_p0_rdata),
        .p1_req_i(p1_req_i), .p1_we_i(p1_we_i), .p1_width_i(p1_width_i),
        .p1_sign_extend_i(p1_sign_extend_i), .p1_addr_i(p1_addr_i), .p1_wdata_i(p1_wdata_i),
        .p1_gnt_o(f_p1_gnt), .p1_rvalid_o(f_p1_rvalid), .p1_rdata_o(f_p1_rdata),
        .mem_addr_o(f_mem_addr), .mem_width_o(f_mem_width),
        .mem_sign_extend_o(f_mem_se), .mem_wdata_o(f_mem_wdata),
        .mem_we_o(f_mem_we), .mem_rdata_i(32'd0)
    );

    // Memory contents seen by the DUT (phys_mem) and by the reference model (ref_mem).
    logic [7:0] phys_mem [DEPTH];
    logic [7:0] ref_mem  [DEPTH];

    function automatic logic [31:0] mem_read(input bit from_ref, input logic [AW-1:0] a,
                                             input logic [1:0] w, input logic se);
        logic [7:0] b [4];
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            b[i] = from_ref ? ref_mem[(int'(a) + i) % DEPTH] : phys_mem[(int'(a) + i) % DEPTH];
        end
        case (w)
            W_BYTE:  r = se ? {{24{b[0][7]}}, b[0]} : {24'd0, b[0]};
            W_HALF:  r = se ? {{16{b[1][7]}}, b[1], b[0]} : {16'd0, b[1], b[0]};
            default: r = {b[3], b[2], b[1], b[0]};
        endcase
        return r;
    endfunction

    task automatic mem_write(input bit to_ref, input logic [AW-1:0] a,
                             input logic [1:0] w, input logic [31:0] d);
        int n;
        n = (w == W_BYTE) ? 1 : (w == W_HALF) ? 2 : 4;
        for (int i = 0; i < n; i++) begin
            if (to_ref) ref_mem[(int'(a) + i) % DEPTH] = d[8*i +: 8];
            else        phys_mem[(int'(a) + i) % DEPTH] = d[8*i +: 8];
        end
    endtask

    always @(posedge clk) begin
        if (mem_we_o) mem_write(1'b0, mem_addr_o, mem_width_o, mem_wdata_o);
        mem_rdata_i <= mem_read(1'b0, mem_addr_o, mem_width_o, mem_sign_extend_o);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else passed++;
    endtask

    // Reference model state: port served last, and responses owed ({port, data}).
    int          last_port = 1;
    logic [32:0] exp_q [$];
    int          f_g0_cnt, f_g1_cnt;

    // One clock of traffic: inputs were set just after the falling edge.
    task automatic step();
        bit e0, e1, rv0, rv1;
        logic [31:0] d0, d1;
        logic [32:0] e;
        #1;
        e0 = 1'b0; e1 = 1'b0;
        if (p0_req_i && p1_req_i) begin
            if (last_port == 1) e0 = 1'b1; else e1 = 1'b1;
        end else begin
            e0 = p0_req_i;
            e1 = p1_req_i;
        end
        check("p0_gnt", p0_gnt_o, e0);
        check("p1_gnt", p1_gnt_o, e1);
        check("mem_we", mem_we_o, e1 && p1_we_i);
        check("fixed_p1_gnt", f_p1_gnt, p1_req_i);
        check("fixed_p0_gnt", f_p0_gnt, p0_req_i && !p1_req_i);
        f_g0_cnt += int'(f_p0_gnt);
        f_g1_cnt += int'(f_p1_gnt);
        if (e0) begin
            check("mem_addr_p0", mem_addr_o, p0_addr_i);
            check("mem_width_p0", mem_width_o, W_WORD);
        end
        if (e1) begin
            check("mem_addr_p1", mem_addr_o, p1_addr_i);
            check("mem_width_p1", mem_width_o, p1_width_i);
            if (p1_we_i) check("mem_wdata", mem_wdata_o, p1_wdata_i);
        end
        rv0 = 1'b0; rv1 = 1'b0; d0 = 32'd0; d1 = 32'd0;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e[32]) begin rv1 = 1'b1; d1 = e[31:0]; end
            else       begin rv0 = 1'b1; d0 = e[31:0]; end
        end
        check("p0_rvalid", p0_rvalid_o, rv0);
        check("p1_rvalid", p1_rvalid_o, rv1);
        check("p0_rdata", p0_rdata_o, d0);
        check("p1_rdata", p1_rdata_o, d1);
        if (e0) begin
            last_port = 0;
            exp_q.push_back({1'b0, mem_read(1'b1, p0_addr_i, W_WORD, 1'b0)});
        end
        if (e1) begin
            last_port = 1;
            if (p1_we_i) mem_write(1'b1, p1_addr_i, p1_width_i, p1_wdata_i);
            else exp_q.push_back({1'b1, mem_read(1'b1, p1_addr_i, p1_width_i, p1_sign_extend_i)});
        end
        @(negedge clk);
        if (e0) p0_req_i = 1'b0;
        if (e1) p1_req_i = 1'b0;
    endtask

    task automatic reset_cycles(input int n);
        rst_i = 1'b1;
        for (int i = 0; i < n; i++) begin
            #1;
            check("rst_p0_gnt", p0_gnt_o, 1'b0);
            check("rst_p1_gnt", p1_gnt_o, 1'b0);
            check("rst_mem_we", mem_we_o, 1'b0);
            check("rst_p0_rvalid", p0_rvalid_o, 1'b0);
            check("rst_p1_rvalid", p1_rvalid_o, 1'b0);
            check("rst_p0_rdata", p0_rdata_o, 32'd0);
            check("rst_p1_rdata", p1_rdata_o, 32'd0);
            check("rst_fixed_gnt", {31'd0, f_p0_gnt | f_p1_gnt}, 32'd0);
            @(negedge clk);
        end
        exp_q.delete();
        last_port = 1;
        rst_i = 1'b0;
    endtask

    task automatic set_p1(input logic we, input logic [1:0] w, input logic se,
                          input logic [AW-1:0] a, input logic [31:0] d);
        p1_req_i = 1'b1; p1_we_i = we; p1_width_i = w;
        p1_sign_extend_i = se; p1_addr_i = a; p1_wdata_i = d;
    endtask

    task automatic rand_p1();
        logic [1:0] w;
        w = 2'($urandom_range(0, 2));
        set_p1(1'($urandom_range(0, 1)), w, 1'($urandom_range(0, 1)),
               AW'($urandom_range(0, 15) * 4 + ((w == W_BYTE) ? $urandom_range(0, 3) :
                                                 (w == W_HALF) ? 2 * $urandom_range(0, 1) : 0)),
               $urandom());
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            phys_mem[i] = 8'($urandom());
            ref_mem[i]  = phys_mem[i];
        end
        rst_i = 1'b1; p0_req_i = 1'b0; p0_addr_i = '0;
        p1_req_i = 1'b0; p1_we_i = 1'b0; p1_width_i = W_WORD;
        p1_sign_extend_i = 1'b0; p1_addr_i = '0; p1_wdata_i = '0;
        @(negedge clk);
        reset_cycles(2);

        // Idle: nothing granted, nothing written, nothing returned.
        for (int i = 0; i < 10; i++) step();

        // Lone port 0 read.
        p0_req_i = 1'b1; p0_addr_i = 10'h010;
        step();
        step();

        // Contended write/read after reset, then read back the written byte.
        reset_cycles(1);
        p0_req_i = 1'b1; p0_addr_i = 10'h000;
        set_p1(1'b1, W_BYTE, 1'b0, 10'h003, 32'h0000_00A5);
        step();
        step();
        set_p1(1'b0, W_WORD, 1'b0, 10'h000, 32'd0);
        step();
        check("readback_byte3", {24'd0, p1_rdata_o[31:24]}, 32'h0000_00A5);
        check("readback_valid", p1_rvalid_o, 1'b1);
        step();

        // Continuous contention: alternation here, p1 every cycle on the fixed instance.
        reset_cycles(1);
        f_g0_cnt = 0; f_g1_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (!p0_req_i) begin p0_req_i = 1'b1; p0_addr_i = AW'($urandom_range(0, 255) * 4); end
            if (!p1_req_i) set_p1(1'b0, W_WORD, 1'b0, AW'($urandom_range(0, 255) * 4), 32'd0);
            step();
        end
        check("fixed_p1_gnt_count", f_g1_cnt, 5);
        check("fixed_p0_gnt_count", f_g0_cnt, 0);
        p0_req_i = 1'b0; p1_req_i = 1'b0;
        step();

        // A granted read is dropped by a reset in the following cycle.
        reset_cycles(1);
        phys_mem[2] = 8'h01; phys_mem[3] = 8'h80;
        ref_mem[2]  = 8'h01; ref_mem[3]  = 8'h80;
        set_p1(1'b0, W_HALF, 1'b1, 10'h002, 32'd0);
        step();
        check("halfword_queued", exp_q[0], {1'b1, 32'hFFFF_8001});
        reset_cycles(1);
        p0_req_i = 1'b1; p0_addr_i = 10'h020;
        set_p1(1'b0, W_WORD, 1'b0, 10'h024, 32'd0);
        step();
        step();
        step();

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            if (!p0_req_i && $urandom_range(0, 3) != 0) begin
                p0_req_i = 1'b1; p0_addr_i = AW'($urandom_range(0, 15) * 4);
            end
            if (!p1_req_i && $urandom_range(0, 3) != 0) rand_p1();
            if ($urandom_range(0, 60) == 0) reset_cycles(1);
            else step();
        end
        p0_req_i = 1'b0; p1_req_i = 1'b0;
        step();
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
